// File: rtl/eth_link_pulse.sv
// eth_link_pulse: Ethernet link pulse generator and link integrity monitor.
//
// Transmit side: a free-running period counter (c_out) emits a single normal
// link pulse (MODE=0) or a 33-slot fast link pulse burst carrying lcw (MODE=1)
// once per period. tx_en suppresses generation and parks the counter at 0.
// Receive side: rx_nlp is synchronised, rising edges are timed against a gap
// timer, and a two-state FSM tracks LINK_FAIL / LINK_PASS.
//
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   tx_en    in   data transmission active, suppresses pulses
//   lcw      in   [15:0] FLP link code word (ignored for MODE=0)
//   rx_nlp   in   asynchronous received link pulse line
//   rx_act   in   synchronous receive activity, keeps the link alive
//   tx_nlp   out  transmitted link pulse
//   go       out  one-cycle strobe at start of each pulse / burst
//   c_out    out  [CNT_W-1:0] period counter
//   link_ok  out  high while in LINK_PASS
module eth_link_pulse #(
    parameter int unsigned PERIOD_CYC  = 800000,
    parameter int unsigned PULSE_CYC   = 5,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SLOT_CYC    = 3125,
    parameter int unsigned MIN_GAP_CYC = 100000,
    parameter int unsigned LOSS_CYC    = 5000000,
    parameter int unsigned PASS_CNT    = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tx_en,
    input  logic [15:0]      lcw,
    input  logic             rx_nlp,
    input  logic             rx_act,
    output logic             tx_nlp,
    output logic             go,
    output logic [CNT_W-1:0] c_out,
    output logic             link_ok
);

    localparam int unsigned OFF_W     = $clog2(SLOT_CYC + 1);
    localparam int unsigned SLOT_W    = 6;
    localparam int unsigned NUM_SLOTS = 33;
    localparam int unsigned GAP_W     = $clog2(LOSS_CYC + 1);
    localparam int unsigned PCNT_W    = $clog2(PASS_CNT + 1);

    typedef enum logic [0:0] {LinkFail, LinkPass} link_state_e;

    // ------------------------------------------------------------------
    // Transmit
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  off_q, off_d;    // offset within current FLP slot
    logic [SLOT_W-1:0] slot_q, slot_d;  // FLP slot index, saturates at 33
    logic [15:0]       lcw_q, lcw_d;
    logic              go_q, go_d;
    logic              tx_q, tx_d;
    logic              pulse;

    always_comb begin
        cnt_d  = cnt_q;
        off_d  = off_q;
        slot_d = slot_q;
        if (tx_en || cnt_q == CNT_W'(PERIOD_CYC - 1)) begin
            cnt_d  = '0;
            off_d  = '0;
            slot_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (off_q == OFF_W'(SLOT_CYC - 1)) begin
                off_d = '0;
                if (slot_q != SLOT_W'(NUM_SLOTS)) begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end else begin
                off_d = off_q + OFF_W'(1);
            end
        end

        go_d  = !tx_en && (cnt_d == '0);
        // Word is captured at burst start so mid-burst lcw changes are ignored
        lcw_d = go_d ? lcw : lcw_q;

        if (MODE == 0) begin
            pulse = cnt_d < CNT_W'(PULSE_CYC);
        end else begin
            // Even slots are clock pulses; odd slot 2k+1 carries lcw[k]
            pulse = (slot_d < SLOT_W'(NUM_SLOTS)) && (off_d < OFF_W'(PULSE_CYC)) &&
                    (!slot_d[0] || lcw_d[slot_d[4:1]]);
        end
        tx_d = !tx_en && pulse;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= CNT_W'(PERIOD_CYC - 1);
            off_q  <= '0;
            slot_q <= '0;
            lcw_q  <= '0;
            go_q   <= 1'b0;
            tx_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            slot_q <= slot_d;
            lcw_q  <= lcw_d;
            go_q   <= go_d;
            tx_q   <= tx_d;
        end
    end

    assign c_out  = cnt_q;
    assign go     = go_q;
    // Gate with the live tx_en so a pulse is cut in the same cycle tx_en rises
    assign tx_nlp = tx_q & ~tx_en;

    // ------------------------------------------------------------------
    // Receive / link integrity
    // ------------------------------------------------------------------
    logic [2:0]        sync_q;  // [1:0] synchroniser, [2] edge-detect history
    logic [GAP_W-1:0]  gap_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic              first_q; // next pulse is the first since reset
    link_state_e       state_q;
    logic              rx_ev;

    assign rx_ev = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '0;
            gap_q   <= '0;
            pcnt_q  <= '0;
            first_q <= 1'b1;
            state_q <= LinkFail;
        end else begin
            sync_q <= {sync_q[1:0], rx_nlp};
            if (rx_ev) begin
                gap_q   <= '0;
                first_q <= 1'b0;
                if (first_q || gap_q >= GAP_W'(MIN_GAP_CYC)) begin
                    if (state_q == LinkFail) begin
                        if (pcnt_q == PCNT_W'(PASS_CNT - 1)) begin
                            state_q <= LinkPass;
                            pcnt_q  <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + PCNT_W'(1);
                        end
                    end
                end else begin
                    // Early pulse: breaks the run but never drops an up link
                    pcnt_q <= '0;
                end
            end else if (rx_act) begin
                gap_q <= '0;
            end else if (gap_q != GAP_W'(LOSS_CYC)) begin
                gap_q <= gap_q + GAP_W'(1);
                if (state_q == LinkPass && gap_q == GAP_W'(LOSS_CYC - 1)) begin
                    state_q <= LinkFail;
                    pcnt_q  <= '0;
                end
            end
        end
    end

    assign link_ok = (state_q == LinkPass);

endmodule

// File: tb/tb_eth_link_pulse.sv
// Scoreboard bench for eth_link_pulse: u0 runs NLP mode, u1 runs FLP mode.
// Stimulus pushes expected (cycle, signal, value) items and expected go cycles;
// a monitor on the falling edge pops and compares them as the cycles arrive.
module tb_eth_link_pulse;

    localparam int unsigned PER = 400;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tx_en0, tx_en1;
    logic [15:0] lcw0, lcw1;
    logic        rx_nlp0, rx_nlp1, rx_act0, rx_act1;
    logic        tx_nlp0, tx_nlp1, go0, go1, link_ok0, link_ok1;
    logic [15:0] c_out0, c_out1;

    always #5 clk = ~clk;

    eth_link_pulse #(
        .PERIOD_CYC(PER), .PULSE_CYC(2), .MODE(0), .SLOT_CYC(10),
        .MIN_GAP_CYC(50), .LOSS_CYC(300), .PASS_CNT(2), .CNT_W(16)
    ) u0 (
        .clk(clk), .resetn(resetn), .tx_en(tx_en0), .lcw(lcw0), .rx_nlp(rx_nlp0),
        .rx_act(rx_act0), .tx_nlp(tx_nlp0), .go(go0), .c_out(c_out0), .link_ok(link_ok0)
    );

    eth_link_pulse #(
        .PERIOD_CYC(PER), .PULSE_CYC(2), .MODE(1), .SLOT_CYC(10),
        .MIN_GAP_CYC(50), .LOSS_CYC(300), .PASS_CNT(2), .CNT_W(16)
    ) u1 (
        .clk(clk), .resetn(resetn), .tx_en(tx_en1), .lcw(lcw1), .rx_nlp(rx_nlp1),
        .rx_act(rx_act1), .tx_nlp(tx_nlp1), .go(go1), .c_out(c_out1), .link_ok(link_ok1)
    );

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    localparam int unsigned S_COUT0 = 0, S_TX0 = 1, S_LINK0 = 2;
    localparam int unsigned S_COUT1 = 3, S_TX1 = 4, S_GO1 = 5;

    chk_t        chk_q[$];
    chk_t        keep_q[$];
    int unsigned go0_q[$], go1_q[$], rise_q[$];
    int unsigned n_checks = 0, n_pass = 0;
    int unsigned b1, b2;
    logic        tx1_prev = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, edge_n, act, exp);
    endtask

    function automatic logic [31:0] sig_val(int unsigned s);
        case (s)
            S_COUT0: return 32'(c_out0);
            S_TX0:   return 32'(tx_nlp0);
            S_LINK0: return 32'(link_ok0);
            S_COUT1: return 32'(c_out1);
            S_TX1:   return 32'(tx_nlp1);
            S_GO1:   return 32'(go1);
            default: return 'x;
        endcase
    endfunction

    task automatic push(int unsigned cyc, int unsigned sig, logic [31:0] exp, string name);
        chk_t c;
        c.cyc  = cyc;
        c.sig  = sig;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic wait_until(int unsigned n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_pulse(int unsigned p);
        wait_until(b2 + p);
        rx_nlp0 = 1'b1;
        wait_until(b2 + p + 3);
        rx_nlp0 = 1'b0;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            keep_q.delete();
            foreach (chk_q[i]) begin
                if (chk_q[i].cyc == edge_n) check(chk_q[i].name, sig_val(chk_q[i].sig), chk_q[i].exp);
                else keep_q.push_back(chk_q[i]);
            end
            chk_q = keep_q;
            if (go0_q.size() > 0 && go0_q[0] == edge_n) begin
                void'(go0_q.pop_front());
                check("u0 go", 32'(go0), 32'd1);
            end else if (go0) begin
                check("u0 go spurious", 32'(go0), 32'd0);
            end
            if (go1_q.size() > 0 && go1_q[0] == edge_n) begin
                void'(go1_q.pop_front());
                check("u1 go", 32'(go1), 32'd1);
            end else if (go1) begin
                check("u1 go spurious", 32'(go1), 32'd0);
            end
            if (tx_nlp1 && !tx1_prev) rise_q.push_back(edge_n);
            tx1_prev = tx_nlp1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        resetn  = 1'b0;
        tx_en0  = 1'b0;
        tx_en1  = 1'b0;
        lcw0    = 16'hA5A5;
        lcw1    = 16'h0001;
        rx_nlp0 = 1'b0;
        rx_nlp1 = 1'b0;
        rx_act0 = 1'b0;
        rx_act1 = 1'b0;

        push(2, S_COUT0, 399, "reset c_out u0");
        push(2, S_TX0,   0,   "reset tx_nlp u0");
        push(2, S_LINK0, 0,   "reset link_ok u0");
        push(2, S_COUT1, 399, "reset c_out u1");
        push(2, S_GO1,   0,   "reset go u1");

        // Segment 1: free-running NLP on u0, FLP bursts on u1
        wait_until(3);
        b1 = edge_n;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go0_q.push_back(b1 + 1 + k * PER);
            go1_q.push_back(b1 + 1 + k * PER);
        end
        push(b1 + 1,   S_COUT0, 0,   "c_out first edge");
        push(b1 + 2,   S_COUT0, 1,   "c_out increment");
        push(b1 + 400, S_COUT0, 399, "c_out top");
        push(b1 + 401, S_COUT0, 0,   "c_out wrap");
        push(b1 + 1,   S_TX0, 1, "nlp high c0");
        push(b1 + 2,   S_TX0, 1, "nlp high c1");
        push(b1 + 3,   S_TX0, 0, "nlp low c2");
        push(b1 + 401, S_TX0, 1, "nlp2 high c0");
        push(b1 + 402, S_TX0, 1, "nlp2 high c1");
        push(b1 + 403, S_TX0, 0, "nlp2 low c2");
        push(b1 + 200, S_LINK0, 0, "link idle");
        push(b1 + 11,  S_TX1, 1, "flp slot1 c10");
        push(b1 + 12,  S_TX1, 1, "flp slot1 c11");
        push(b1 + 13,  S_TX1, 0, "flp slot1 end");
        push(b1 + 21,  S_TX1, 1, "flp slot2");
        push(b1 + 31,  S_TX1, 0, "flp slot3 empty");
        push(b1 + 311, S_TX1, 0, "flp slot31 empty");
        push(b1 + 321, S_TX1, 1, "flp slot32");
        push(b1 + 331, S_TX1, 0, "flp no slot33");
        push(b1 + 431, S_TX1, 1, "flp2 slot3 lcw ffff");
        push(b1 + 802, S_TX1, 1, "flp3 slot0");
        // Reset lands mid-cycle at b1+811, before that cycle's sample
        push(b1 + 811, S_TX1,   0,   "async reset tx_nlp u1");
        push(b1 + 811, S_COUT1, 399, "async reset c_out u1");
        push(b1 + 811, S_GO1,   0,   "async reset go u1");
        push(b1 + 811, S_COUT0, 399, "async reset c_out u0");
        push(b1 + 813, S_LINK0, 0,   "held reset link_ok");

        wait_until(b1 + 5);
        lcw1 = 16'hFFFF;  // must not disturb the burst in progress
        wait_until(b1 + 811);
        #1;
        resetn = 1'b0;
        wait_until(b1 + 814);

        // Segment 2: restart, tx_en handling, receive link integrity
        b2 = edge_n;
        resetn = 1'b1;
        go0_q.push_back(b2 + 1);
        go0_q.push_back(b2 + 502);
        go0_q.push_back(b2 + 902);
        go0_q.push_back(b2 + 1302);
        go1_q.push_back(b2 + 1);
        push(b2 + 1,   S_COUT0, 0,   "restart c_out u0");
        push(b2 + 1,   S_TX0,   1,   "restart tx_nlp u0");
        push(b2 + 1,   S_COUT1, 0,   "restart c_out u1");
        push(b2 + 1,   S_TX1,   1,   "restart tx_nlp u1");
        push(b2 + 2,   S_TX0,   0,   "tx_en truncates nlp");
        push(b2 + 2,   S_TX1,   0,   "tx_en truncates flp");
        push(b2 + 2,   S_COUT0, 1,   "c_out before hold");
        push(b2 + 3,   S_COUT0, 0,   "c_out held");
        push(b2 + 50,  S_TX0,   0,   "tx_nlp off under tx_en");
        push(b2 + 102, S_COUT0, 0,   "c_out held end");
        push(b2 + 103, S_COUT0, 1,   "c_out resumes at 1");
        push(b2 + 501, S_COUT0, 399, "c_out top after tx_en");
        push(b2 + 502, S_COUT0, 0,   "c_out wrap after tx_en");
        push(b2 + 503, S_TX0,   1,   "nlp after tx_en");
        push(b2 + 504, S_TX0,   0,   "nlp end after tx_en");
        push(b2 + 3,   S_COUT1, 0,   "u1 c_out held");
        push(b2 + 200, S_COUT1, 0,   "u1 c_out held long");
        push(b2 + 200, S_TX1,   0,   "u1 tx_nlp off");
        push(b2 + 12,   S_LINK0, 0, "link before 1st pulse");
        push(b2 + 112,  S_LINK0, 0, "link after 1 pulse");
        push(b2 + 113,  S_LINK0, 1, "link up on 2nd pulse");
        push(b2 + 412,  S_LINK0, 1, "link before loss");
        push(b2 + 413,  S_LINK0, 0, "link lost");
        push(b2 + 503,  S_LINK0, 0, "fail 1 valid");
        push(b2 + 524,  S_LINK0, 0, "fail early pulse");
        push(b2 + 564,  S_LINK0, 0, "fail early pulses");
        push(b2 + 653,  S_LINK0, 0, "early cleared count");
        push(b2 + 752,  S_LINK0, 0, "before re-pass");
        push(b2 + 753,  S_LINK0, 1, "link re-pass");
        push(b2 + 774,  S_LINK0, 1, "early in pass keeps link");
        push(b2 + 1103, S_LINK0, 1, "rx_act keeps link");
        push(b2 + 1499, S_LINK0, 1, "link before loss 2");
        push(b2 + 1500, S_LINK0, 0, "link lost 2");

        fork
            begin
                wait_until(b2 + 2);
                tx_en0 = 1'b1;
                tx_en1 = 1'b1;
                wait_until(b2 + 102);
                tx_en0 = 1'b0;
            end
            begin
                rx_pulse(10);
                rx_pulse(110);
                rx_pulse(500);
                rx_pulse(520);
                rx_pulse(540);
                rx_pulse(560);
                rx_pulse(650);
                rx_pulse(750);
                wait_until(b2 + 760);
                rx_act0 = 1'b1;
                rx_pulse(770);
                wait_until(b2 + 1200);
                rx_act0 = 1'b0;
            end
        join

        wait_until(b2 + 1550);
        @(negedge clk);
        #1;

        cnt = 0;
        foreach (rise_q[i]) if (rise_q[i] >= b1 + 1 && rise_q[i] <= b1 + 400) cnt++;
        check("flp burst lcw 0001 pulse count", cnt, 18);
        cnt = 0;
        foreach (rise_q[i]) if (rise_q[i] >= b1 + 401 && rise_q[i] <= b1 + 800) cnt++;
        check("flp burst lcw ffff pulse count", cnt, 33);

        foreach (chk_q[i]) begin
            n_checks++;
            $display("FAIL %s never sampled (cycle %0d)", chk_q[i].name, chk_q[i].cyc);
        end
        foreach (go0_q[i]) begin
            n_checks++;
            $display("FAIL u0 go missing at cycle %0d", go0_q[i]);
        end
        foreach (go1_q[i]) begin
            n_checks++;
            $display("FAIL u1 go missing at cycle %0d", go1_q[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
